// File: rtl/barrel_shift_sequencer_pkg.sv
// Shared types and constants for the barrel-shift sequencer: FSM states,
// default widths and the largest legal shift amount for a 24-bit word.
package bs_seq_pkg;
  localparam int DEF_W     = 24;
  localparam int DEF_AMT_W = 5;
  localparam int MAX_AMT   = 23;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STEP_REQ = 2'd1,
    AUTO     = 2'd2,
    AUTO_REQ = 2'd3
  } state_e;
endpackage

// File: rtl/barrel_shift_sequencer_key_edge.sv
// Registered rising-edge detector for the synchronized keys. History resets
// to all ones so a key held through reset produces no event on release of rst.
module key_edge_detect #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] key,
  output logic [N-1:0] rise
);
  logic [N-1:0] hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '1;
      rise <= '0;
    end else begin
      hist <= key;
      rise <= key & ~hist;
    end
  end
endmodule

// File: rtl/barrel_shift_sequencer.sv
// Key/strobe driven sequencer that feeds an external barrel shifter through a
// req/ack handshake and displays the working data word and step count.
module barrel_shift_sequencer
  import bs_seq_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [3:0]       key,
  input  logic [9:0]       sw,
  output logic             bs_req,
  output logic [W-1:0]     bs_in,
  output logic [AMT_W-1:0] bs_amt,
  output logic             bs_left,
  output logic             bs_rot,
  input  logic             bs_ack,
  input  logic [W-1:0]     bs_out,
  output logic [W-1:0]     disp,
  output logic [5:0]       disp_en,
  output logic [5:0]       disp_dot,
  output logic [9:0]       led
);
  // Handshake: bs_req rises with bs_in/bs_amt/bs_left/bs_rot registered on the
  // same edge; all four stay frozen until the edge that samples bs_ack high,
  // where bs_req drops and bs_out is captured. bs_ack with bs_req low is ignored.

  logic [3:0]       rise;
  state_e           state;
  logic [W-1:0]     data;
  logic [7:0]       count;
  logic             rot;
  logic             stop;
  logic             ev_load;
  logic             ev_step;
  logic             ev_auto;
  logic             issue;
  logic             ack;
  logic [W-1:0]     load_word;
  logic [4:0]       sw_amt;
  logic [AMT_W-1:0] amt_clamped;

  key_edge_detect #(.N(4)) u_keys (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .rise (rise)
  );

  // Priority key[0] > key[1] > key[2]; a losing event is simply dropped.
  always_comb begin
    ev_load = rise[0];
    ev_step = rise[1] & ~rise[0];
    ev_auto = rise[2] & ~rise[1] & ~rise[0];
  end

  always_comb begin
    load_word = '0;
    for (int i = 0; i < W; i++) begin
      load_word[i] = sw[i % 4];
    end
  end

  assign sw_amt      = sw[9:5];
  assign amt_clamped = (sw_amt > 5'(MAX_AMT)) ? AMT_W'(MAX_AMT) : AMT_W'(sw_amt);
  assign ack         = bs_req & bs_ack;
  assign issue       = ((state == IDLE) && ev_step) ||
                       ((state == AUTO) && !ev_load && !ev_auto && en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      count   <= '0;
      rot     <= 1'b0;
      stop    <= 1'b0;
      bs_req  <= 1'b0;
      bs_in   <= '0;
      bs_amt  <= '0;
      bs_left <= 1'b0;
      bs_rot  <= 1'b0;
    end else begin
      if (rise[3]) rot <= ~rot;

      // rot here is the pre-toggle value, so a same-edge key[3] affects the next request.
      if (issue) begin
        bs_req  <= 1'b1;
        bs_in   <= data;
        bs_amt  <= amt_clamped;
        bs_left <= sw[4];
        bs_rot  <= rot;
      end

      case (state)
        IDLE: begin
          if (ev_load) begin
            data  <= load_word;
            count <= '0;
          end else if (ev_step) begin
            state <= STEP_REQ;
          end else if (ev_auto) begin
            state <= AUTO;
          end
        end
        STEP_REQ: begin
          if (ack) begin
            bs_req <= 1'b0;
            data   <= bs_out;
            count  <= count + 8'd1;
            state  <= IDLE;
          end
        end
        AUTO: begin
          if (ev_load) begin
            data  <= load_word;
            count <= '0;
          end else if (ev_auto) begin
            state <= IDLE;
          end else if (en) begin
            state <= AUTO_REQ;
          end
        end
        AUTO_REQ: begin
          if (ack) begin
            bs_req <= 1'b0;
            data   <= bs_out;
            count  <= count + 8'd1;
            state  <= (stop || ev_auto) ? IDLE : AUTO;
            stop   <= 1'b0;
          end else if (ev_auto) begin
            stop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign disp     = data;
  assign disp_en  = 6'b111111;
  assign disp_dot = {bs_req, 5'b00000};
  assign led      = {rot, (state == AUTO) || (state == AUTO_REQ), count};
endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Randomized bench for barrel_shift_sequencer: a behavioural model predicts
// each shifter request and each completed result; a monitor checks them.
module tb_barrel_shift_sequencer;
  localparam int W     = 24;
  localparam int AMT_W = 5;
  localparam int REQ_W = W + AMT_W + 2;
  localparam int RES_W = W + 8 + 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [3:0]       key;
  logic [9:0]       sw;
  logic             bs_req;
  logic [W-1:0]     bs_in;
  logic [AMT_W-1:0] bs_amt;
  logic             bs_left;
  logic             bs_rot;
  logic             bs_ack;
  logic [W-1:0]     bs_out;
  logic [W-1:0]     disp;
  logic [5:0]       disp_en;
  logic [5:0]       disp_dot;
  logic [9:0]       led;

  barrel_shift_sequencer #(.W(W), .AMT_W(AMT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .key(key), .sw(sw),
    .bs_req(bs_req), .bs_in(bs_in), .bs_amt(bs_amt), .bs_left(bs_left),
    .bs_rot(bs_rot), .bs_ack(bs_ack), .bs_out(bs_out),
    .disp(disp), .disp_en(disp_en), .disp_dot(disp_dot), .led(led)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [W-1:0] ref_data;
  logic [7:0]   ref_count;
  bit           ref_rot, ref_auto, ref_out, ref_stop;
  int           pend_amt;
  bit           pend_left, pend_rot;
  int           ack_lat = 3;
  int           age = 0;
  bit           strobes = 0;
  int           strobe_cnt = 0;
  int           n_issued = 0;
  int           n_done = 0;

  logic [REQ_W-1:0] req_q[$];
  logic [RES_W-1:0] res_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] shift_ref(input logic [W-1:0] d, input int amt,
                                             input bit left, input bit rot);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < amt; i++) begin
      if (left) r = rot ? {r[W-2:0], r[W-1]} : {r[W-2:0], 1'b0};
      else      r = rot ? {r[0], r[W-1:1]}   : {1'b0, r[W-1:1]};
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rep_nibble(input logic [3:0] n);
    logic [W-1:0] r;
    for (int i = 0; i < W / 4; i++) r[i*4 +: 4] = n;
    return r;
  endfunction

  task automatic issue_model();
    int a;
    a = int'(sw[9:5]);
    if (a > 23) a = 23;
    req_q.push_back({ref_data, AMT_W'(a), sw[4], ref_rot});
    pend_amt  = a;
    pend_left = sw[4];
    pend_rot  = ref_rot;
    ref_out   = 1;
    n_issued++;
  endtask

  task automatic complete_model();
    ref_data  = shift_ref(ref_data, pend_amt, pend_left, pend_rot);
    ref_count = ref_count + 8'd1;
    res_q.push_back({ref_data, ref_count, 8'(ack_lat)});
    ref_out = 0;
    n_done++;
    if (ref_auto) begin
      if (ref_stop) ref_auto = 0;
      ref_stop = 0;
    end
  endtask

  task automatic reset_model();
    ref_data = '0; ref_count = '0;
    ref_rot = 0; ref_auto = 0; ref_out = 0; ref_stop = 0;
  endtask

  // driver: one clock per call; strobe generator, then shifter responder
  task automatic cycle();
    @(negedge clk);
    en = 1'b0;
    if (strobes) begin
      strobe_cnt++;
      if (strobe_cnt % 5 == 0) begin
        en = 1'b1;
        if (ref_auto && !ref_out) issue_model();
      end
    end
    bs_ack = 1'b0;
    if (bs_req) begin
      age++;
      if (age == ack_lat) begin
        bs_ack = 1'b1;
        bs_out = shift_ref(bs_in, int'(bs_amt), bs_left, bs_rot);
        complete_model();
      end
    end else begin
      age = 0;
    end
  endtask

  task automatic press_key(input logic [3:0] mask);
    int sel;
    cycle();
    key = mask;
    sel = mask[0] ? 0 : mask[1] ? 1 : mask[2] ? 2 : -1;
    case (sel)
      0: if (!ref_out) begin ref_data = rep_nibble(sw[3:0]); ref_count = '0; end
      1: if (!ref_auto && !ref_out) issue_model();
      2: if (!ref_out) ref_auto = !ref_auto;
         else if (ref_auto) ref_stop = 1;
      default: ;
    endcase
    if (mask[3]) ref_rot = !ref_rot;
    cycle();
    key = 4'b0000;
    repeat (3) cycle();
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 300; i++) begin
      if (!ref_out && !bs_req) break;
      cycle();
    end
    check("handshake_timeout", 64'(i < 300), 64'(1));
  endtask

  task automatic check_state(input string name);
    check({name, "_disp"}, 64'(disp), 64'(ref_data));
    check({name, "_led"}, 64'(led), 64'({ref_rot, ref_auto, ref_count}));
  endtask

  // monitor / scoreboard
  bit prev_req = 0;
  int hi_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_req = 0;
      hi_cnt = 0;
    end else begin
      check("disp_dot", 64'(disp_dot), 64'({bs_req, 5'b00000}));
      check("disp_en", 64'(disp_en), 64'(6'b111111));
      if (bs_req && !prev_req) begin
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req actual=%0h expected=none", {bs_in, bs_amt, bs_left, bs_rot});
        end else begin
          logic [REQ_W-1:0] e;
          e = req_q.pop_front();
          if ({bs_in, bs_amt, bs_left, bs_rot} !== e) begin
            errors++;
            $display("FAIL req_fields actual=%0h expected=%0h", {bs_in, bs_amt, bs_left, bs_rot}, e);
          end
        end
      end
      if (bs_req) hi_cnt++;
      if (!bs_req && prev_req) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done actual=%0h expected=none", disp);
        end else begin
          logic [RES_W-1:0] r;
          r = res_q.pop_front();
          if ({disp, led[7:0], 8'(hi_cnt)} !== r) begin
            errors++;
            $display("FAIL result actual=%0h expected=%0h", {disp, led[7:0], 8'(hi_cnt)}, r);
          end
        end
        hi_cnt = 0;
      end
      prev_req = bs_req;
    end
  end

  initial begin
    int i;
    rst = 1'b1; en = 1'b0; bs_ack = 1'b0; bs_out = '0;
    key = 4'b0101;
    sw  = 10'h005;
    reset_model();
    repeat (3) cycle();
    check("rst_disp", 64'(disp), 64'(0));
    check("rst_led", 64'(led), 64'(0));
    check("rst_bs", 64'({bs_req, bs_in, bs_amt, bs_left, bs_rot}), 64'(0));
    rst = 1'b0;
    repeat (4) cycle();
    key = 4'b0000;
    repeat (3) cycle();
    check_state("held_key");

    // load pattern
    sw = 10'h00A;
    press_key(4'b0001);
    check_state("load_a");

    // make data 0x000001: load 0x111111, logical right by 20
    sw = 10'h001;
    press_key(4'b0001);
    sw = {5'd20, 1'b0, 4'h1};
    ack_lat = 2;
    press_key(4'b0010);
    wait_done();
    check_state("to_one");

    // left 4 logical, ack after 3 cycles
    sw = {5'd4, 1'b1, 4'h1};
    ack_lat = 3;
    press_key(4'b0010);
    wait_done();
    check_state("step_left4");

    // 0x000010 -> rotate right by 5 -> 0x800000, then rotate left 0 (amount 0 handshake)
    press_key(4'b1000);
    sw = {5'd5, 1'b0, 4'h1};
    press_key(4'b0010);
    wait_done();
    sw = {5'd0, 1'b1, 4'h1};
    ack_lat = 1;
    press_key(4'b0010);
    wait_done();
    check_state("amt_zero");

    // amount clamp with rotate right
    sw = {5'd31, 1'b0, 4'h1};
    ack_lat = 4;
    press_key(4'b0010);
    wait_done();
    check_state("clamp");

    // same-cycle load and step: load only
    sw = {5'd3, 1'b1, 4'h7};
    press_key(4'b0011);
    repeat (4) cycle();
    check_state("load_wins");

    // random key combinations in manual mode
    for (i = 0; i < 30; i++) begin
      sw = 10'($urandom_range(0, 1023));
      ack_lat = $urandom_range(1, 6);
      case ($urandom_range(0, 3))
        0: press_key(4'b0001);
        1: press_key(4'b0010);
        2: press_key(4'b1000);
        default: press_key(4'($urandom_range(1, 15)));
      endcase
      wait_done();
      check_state("rand");
    end
    if (ref_auto) press_key(4'b0100);

    // auto mode: strobe every 5, ack latency 7
    sw = 10'h003;
    press_key(4'b0001);
    sw = {5'd3, 1'b1, 4'h3};
    ack_lat = 7;
    n_issued = 0;
    n_done = 0;
    press_key(4'b0100);
    check_state("auto_on");
    strobe_cnt = 0;
    strobes = 1;
    repeat (60) cycle();
    for (i = 0; i < 100; i++) begin
      if (bs_req) break;
      cycle();
    end
    check("auto_req_seen", 64'(i < 100), 64'(1));
    press_key(4'b0100);
    repeat (40) cycle();
    strobes = 0;
    wait_done();
    check_state("auto_stop");
    check("auto_issued", 64'(n_issued >= 5), 64'(1));
    check("auto_balanced", 64'(n_issued), 64'(n_done));

    // reset while a request is outstanding
    sw = {5'd2, 1'b1, 4'h9};
    ack_lat = 50;
    press_key(4'b0010);
    check("pre_rst_req", 64'(bs_req), 64'(1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async_req", 64'(bs_req), 64'(0));
    reset_model();
    cycle();
    cycle();
    rst = 1'b0;
    cycle();
    bs_ack = 1'b1;
    bs_out = 24'hABCDEF;
    repeat (3) cycle();
    check_state("stale_ack");

    check("req_q_empty", 64'(req_q.size()), 64'(0));
    check("res_q_empty", 64'(res_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
